multicycle_ctrl: RTL



---
 rtl/cpu_pkg.sv | 114 +++++++++++
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/multicycle_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, ULA ops, mux selects,
// error codes, controller states and the per-state Moore output decode.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;

  localparam logic [2:0] ULA_LOAD = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;
  localparam logic [2:0] ULA_INC  = 3'b100;
  localparam logic [2:0] ULA_NOT  = 3'b101;
  localparam logic [2:0] ULA_XOR  = 3'b110;
  localparam logic [2:0] ULA_CMP  = 3'b111;

  localparam logic       ULAA_PC      = 1'b0;
  localparam logic       ULAA_A       = 1'b1;
  localparam logic [1:0] ULAB_B       = 2'b00;
  localparam logic [1:0] ULAB_FOUR    = 2'b01;
  localparam logic [1:0] ULAB_IMM     = 2'b10;
  localparam logic [1:0] ULAB_IMM_SH2 = 2'b11;
  localparam logic       WREG_RT      = 1'b0;
  localparam logic       WREG_RD      = 1'b1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [3:0] {
    RST_ST,
    FETCH,
    IR_LD,
    DECODE,
    EX_R,
    EX_ADDI,
    EX_ADDIU,
    OVF,
    ILLEGAL
  } state_t;

  typedef struct packed {
    logic       pc_w;
    logic       ir_w;
    logic       ab_w;
    logic       rb_req;
    logic       of_trap;
    logic       m_wreg;
    logic       m_ulaa;
    logic [1:0] m_ulab;
    logic [2:0] ula_c;
    logic       reset_out;
    logic       halted;
    logic [1:0] err_code;
  } ctrl_t;

  // rb_req/of_trap are combined with Of outside the register so the
  // write-back enable can drop in the very cycle the overflow appears.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      RST_ST: c.reset_out = 1'b1;
      FETCH: begin
        c.m_ulaa = ULAA_PC;
        c.m_ulab = ULAB_FOUR;
        c.ula_c  = ULA_ADD;
      end
      IR_LD: begin
        c.ir_w   = 1'b1;
        c.pc_w   = 1'b1;
        c.m_ulaa = ULAA_PC;
        c.m_ulab = ULAB_FOUR;
        c.ula_c  = ULA_ADD;
      end
      DECODE: c.ab_w = 1'b1;
      EX_R: begin
        c.m_ulaa  = ULAA_A;
        c.m_ulab  = ULAB_B;
        c.ula_c   = ULA_ADD;
        c.m_wreg  = WREG_RD;
        c.rb_req  = 1'b1;
        c.of_trap = 1'b1;
      end
      EX_ADDI: begin
        c.m_ulaa  = ULAA_A;
        c.m_ulab  = ULAB_IMM;
        c.ula_c   = ULA_ADD;
        c.m_wreg  = WREG_RT;
        c.rb_req  = 1'b1;
        c.of_trap = 1'b1;
      end
      EX_ADDIU: begin
        c.m_ulaa = ULAA_A;
        c.m_ulab = ULAB_IMM;
        c.ula_c  = ULA_ADD;
        c.m_wreg = WREG_RT;
        c.rb_req = 1'b1;
      end
      OVF: begin
        c.halted   = 1'b1;
        c.err_code = ERR_OVF;
      end
      ILLEGAL: begin
        c.halted   = 1'b1;
        c.err_code = ERR_ILLEGAL;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the
// single-ALU datapath (slave).
interface multicycle_ctrl_if #(parameter int CNT_W = 16);

  logic             Of;
  logic             Ng;
  logic             Zr;
  logic             Eq;
  logic             Gt;
  logic             Lt;
  logic [5:0]       OPCODE;
  logic             PC_w;
  logic             MEM_w;
  logic             IR_w;
  logic             RB_w;
  logic             AB_w;
  logic [2:0]       ULA_c;
  logic             M_WREG;
  logic             M_ULAA;
  logic [1:0]       M_ULAB;
  logic             reset_out;
  logic             halted;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] retired;

  modport master (
    input  Of, Ng, Zr, Eq, Gt, Lt, OPCODE,
    output PC_w, MEM_w, IR_w, RB_w, AB_w, ULA_c, M_WREG, M_ULAA, M_ULAB,
           reset_out, halted, err_code, retired
  );

  modport slave (
    output Of, Ng, Zr, Eq, Gt, Lt, OPCODE,
    input  PC_w, MEM_w, IR_w, RB_w, AB_w, ULA_c, M_WREG, M_ULAA, M_ULAB,
           reset_out, halted, err_code, retired
  );

endinterface

// File: rtl/multicycle_ctrl.sv
// Moore multicycle controller: RST_ST hold | FETCH mem wait | IR_LD IR+PC write |
// DECODE A/B load | EX_* write-back | OVF/ILLEGAL absorbing halt.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_retired;
  logic             w_rb_w;

  // Outputs are registered alongside the state by decoding the target state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RST_ST;
      r_ctrl    <= ctrl_decode(RST_ST);
      r_cnt     <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        RST_ST: begin
          if (r_cnt == 3'd0) begin
            r_cnt <= 3'd1;
          end else begin
            r_cnt   <= '0;
            r_state <= FETCH;
            r_ctrl  <= ctrl_decode(FETCH);
          end
        end
        FETCH: begin
          if (r_cnt == WAIT_LAST) begin
            r_cnt   <= '0;
            r_state <= IR_LD;
            r_ctrl  <= ctrl_decode(IR_LD);
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        IR_LD: begin
          r_state <= DECODE;
          r_ctrl  <= ctrl_decode(DECODE);
        end
        DECODE: begin
          case (bus.OPCODE)
            OP_RTYPE: begin
              r_state <= EX_R;
              r_ctrl  <= ctrl_decode(EX_R);
            end
            OP_ADDI: begin
              r_state <= EX_ADDI;
              r_ctrl  <= ctrl_decode(EX_ADDI);
            end
            OP_ADDIU: begin
              r_state <= EX_ADDIU;
              r_ctrl  <= ctrl_decode(EX_ADDIU);
            end
            default: begin
              r_state <= ILLEGAL;
              r_ctrl  <= ctrl_decode(ILLEGAL);
            end
          endcase
        end
        EX_R, EX_ADDI: begin
          if (bus.Of) begin
            r_state <= OVF;
            r_ctrl  <= ctrl_decode(OVF);
          end else begin
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= FETCH;
            r_ctrl    <= ctrl_decode(FETCH);
          end
        end
        EX_ADDIU: begin
          r_retired <= r_retired + CNT_W'(1);
          r_state   <= FETCH;
          r_ctrl    <= ctrl_decode(FETCH);
        end
        OVF, ILLEGAL: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ILLEGAL;
          r_ctrl  <= ctrl_decode(ILLEGAL);
        end
      endcase
    end
  end

  assign w_rb_w = r_ctrl.rb_req & ~(r_ctrl.of_trap & bus.Of);

  assign bus.PC_w      = r_ctrl.pc_w;
  assign bus.MEM_w     = 1'b0;
  assign bus.IR_w      = r_ctrl.ir_w;
  assign bus.RB_w      = w_rb_w;
  assign bus.AB_w      = r_ctrl.ab_w;
  assign bus.ULA_c     = r_ctrl.ula_c;
  assign bus.M_WREG    = r_ctrl.m_wreg;
  assign bus.M_ULAA    = r_ctrl.m_ulaa;
  assign bus.M_ULAB    = r_ctrl.m_ulab;
  assign bus.reset_out = r_ctrl.reset_out;
  assign bus.halted    = r_ctrl.halted;
  assign bus.err_code  = r_ctrl.err_code;
  assign bus.retired   = r_retired;

endmodule
